fp_sub_seq: RTL and testbench
=============================

Name: fp_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor that computes result = A - B.
- It is the inverse-direction companion to the combinational float adder in the FP ALU.
- Uses a start/done handshake. Alignment and normalisation shift one bit per clock, which avoids an unbounded combinational loop.
- Sits beside the adder in the ALU operation mux; the ALU controller sequences it.

Parameters:
WIDTH, 32, operand/result width; only 32 (8-bit exponent, 23-bit fraction) is supported.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend, sampled on the accepting edge
B  input  WIDTH  subtrahend, sampled on the accepting edge
result  output  WIDTH  A - B; held stable from done until the next done
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; result is valid in the same cycle

Behaviour:
- Reset (asynchronous, any state): state=IDLE, result=0, busy=0, done=0, internal registers cleared. An operation in flight is abandoned and no done is issued.
- Operand model:
  - Exponent field 0 means value zero, with mantissa {0,frac}; otherwise the mantissa is {1,frac}.
  - No denormals, NaN or Inf inputs are supported.
  - Truncation throughout; there are no guard bits.
- IDLE:
  - On start=1, register the operands and go to ALIGN.
  - Effective B sign = ~B[31].
  - Larger operand = greater {exp,frac}; on a tie, A is the larger.
  - diff = ExpL - ExpS (8-bit, unsigned). If diff > 24, load the small mantissa as 0 and diff_cnt as 0; otherwise diff_cnt = diff.
  - start=0 leaves the block in IDLE.
- ALIGN:
  - If diff_cnt != 0: shift the small mantissa right 1 bit, decrement diff_cnt.
  - If diff_cnt == 0: go to ADDSUB.
- ADDSUB (1 cycle):
  - Signs equal: sum = MantL + MantS.
  - Signs differ: sum = MantL - MantS.
  - Width is 25 bits, where bit 24 is the carry.
  - Result sign = sign of the larger operand; exponent = ExpL. Go to NORM.
- NORM (evaluate in order, one action per cycle):
  - (a) Carry set: shift right 1, exponent+1, go to DONE.
  - (b) Mantissa == 0: force result to 0x00000000 (positive zero), go to DONE.
  - (c) Bit 23 set: go to DONE.
  - (d) Otherwise: if exponent == 1, underflow, force 0x00000000 and go to DONE; else shift left 1, exponent-1, stay in NORM.
- Overflow: if the exponent reaches 255 in (a), result = {sign, 8'hFF, 23'h0}.
- DONE:
  - result = {sign, exp, mant[22:0]}, done=1 for exactly this cycle, busy=1.
  - Next state is IDLE. A start in DONE is ignored.
- Latency: done asserts 4 + d + n cycles after the accepting edge.
  - d = diff_cnt loaded (0..24).
  - n = number of NORM left shifts.
- Back-to-back: start may be accepted on the first IDLE cycle after DONE.
- Busy: start while busy=1 has no effect; no queuing.
- Operand changes on A/B after acceptance do not affect the operation in flight.

Test Plan:
- Direct path: A=0x40400000 (3.0), B=0x3F800000 (1.0) -> result=0x40000000. done exactly 5 cycles after the accepting edge (d=1, n=0).
- Opposite signs: A=0x3F800000, B=0xBF800000 (1.0-(-1.0)) -> carry path, result=0x40000000. A=0x7F7FFFFF, B=0xFF7FFFFF -> 0x7F800000 (overflow to +Inf).
- Negative result with normalisation: A=0x3F800000, B=0x3FC00000 (1.0-1.5) -> result=0xBF000000 after one left shift, 5 cycles. A=B=0x3F800000 -> 0x00000000.
- Large exponent gap: A=0x4B800000, B=0x3F800000 -> 0x4B800000 after 24 ALIGN cycles (28 total). B exponent 40 below A -> small mantissa forced 0, d=0, latency 4.
- Handshake: start held high for 10 cycles -> one operation, one done pulse. Two ops issued back-to-back -> second done follows first by its own latency+1. result stable between done pulses.
- Reset mid-op: assert rst during ALIGN of the gap case -> busy/done/result=0 immediately (asynchronous). A fresh start after release completes correctly.

Source files
------------

// File: rtl/fp_sub_seq.sv
// Sequential single-precision subtractor: result = A - B.
// Alignment and normalisation move one bit per clock.
module fp_sub_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADDSUB,
    NORM,
    DONE
  } stateT;

  stateT state, stateNext;

  logic        signL, signS;
  logic [7:0]  expR;
  logic [23:0] mantL, mantS;
  logic [24:0] mant;
  logic [4:0]  diffCnt;
  logic [31:0] resultQ;

  logic        aGe;
  logic [7:0]  expA, expB, expL, expS, diff;
  logic [23:0] mantA, mantB;
  logic        carry, isZero, isNorm;

  assign expA  = A[30:23];
  assign expB  = B[30:23];
  assign mantA = {|expA, A[22:0]};
  assign mantB = {|expB, B[22:0]};
  // Magnitude compare ignores sign; a tie keeps A as the larger.
  assign aGe   = A[30:0] >= B[30:0];
  assign expL  = aGe ? expA : expB;
  assign expS  = aGe ? expB : expA;
  assign diff  = expL - expS;

  assign carry  = mant[24];
  assign isZero = mant == 25'd0;
  assign isNorm = !mant[24] && mant[23];

  assign result = resultQ;
  assign busy   = state != IDLE;
  assign done   = state == DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = ALIGN;
      ALIGN:   if (diffCnt == 5'd0) stateNext = ADDSUB;
      ADDSUB:  stateNext = NORM;
      NORM: begin
        if (carry || isZero || isNorm || expR <= 8'd1)
          stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signL   <= 1'b0;
      signS   <= 1'b0;
      expR    <= 8'd0;
      mantL   <= 24'd0;
      mantS   <= 24'd0;
      mant    <= 25'd0;
      diffCnt <= 5'd0;
      resultQ <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            signL <= aGe ? A[31] : ~B[31];
            signS <= aGe ? ~B[31] : A[31];
            expR  <= expL;
            mantL <= aGe ? mantA : mantB;
            if (diff > 8'd24) begin
              mantS   <= 24'd0;
              diffCnt <= 5'd0;
            end else begin
              mantS   <= aGe ? mantB : mantA;
              diffCnt <= diff[4:0];
            end
          end
        end
        ALIGN: begin
          if (diffCnt != 5'd0) begin
            mantS   <= mantS >> 1;
            diffCnt <= diffCnt - 5'd1;
          end
        end
        ADDSUB: begin
          if (signL == signS)
            mant <= {1'b0, mantL} + {1'b0, mantS};
          else
            mant <= {1'b0, mantL} - {1'b0, mantS};
        end
        NORM: begin
          unique case (1'b1)
            carry: begin
              mant <= mant >> 1;
              expR <= expR + 8'd1;
              if (expR == 8'd254)
                resultQ <= {signL, 8'hFF, 23'd0};
              else
                resultQ <= {signL, expR + 8'd1, mant[23:1]};
            end
            isZero: resultQ <= 32'd0;
            isNorm: resultQ <= {signL, expR, mant[22:0]};
            default: begin
              if (expR <= 8'd1) begin
                resultQ <= 32'd0;
              end else begin
                mant <= mant << 1;
                expR <= expR - 8'd1;
              end
            end
          endcase
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: arithmetic reference model, per-cycle
// output compare, and directed vectors with literal expectations.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        busy, done;

  always #5 clk = ~clk;

  fp_sub_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .result(result),
    .busy(busy),
    .done(done)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: real-valued rules on plain integers.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    bit aBig, s, ss, uf;
    int el, es, ml, ms, m, d, e, n;
    aBig = a[30:0] >= b[30:0];
    s  = aBig ? a[31] : ~b[31];
    ss = aBig ? ~b[31] : a[31];
    el = aBig ? int'(a[30:23]) : int'(b[30:23]);
    es = aBig ? int'(b[30:23]) : int'(a[30:23]);
    ml = aBig ? int'(a[22:0]) : int'(b[22:0]);
    ms = aBig ? int'(b[22:0]) : int'(a[22:0]);
    if (el != 0) ml = ml + (1 << 23);
    if (es != 0) ms = ms + (1 << 23);
    d = el - es;
    if (d > 24) begin
      ms = 0;
      d = 0;
    end else begin
      ms = ms / (1 << d);
    end
    m = (s == ss) ? ml + ms : ml - ms;
    e = el;
    n = 0;
    uf = 0;
    if (m >= (1 << 24)) begin
      m = m / 2;
      e = e + 1;
      r = (e == 255) ? {s, 8'hFF, 23'h0} : {s, 8'(e), 23'(m)};
    end else if (m == 0) begin
      r = 32'd0;
    end else begin
      while (m < (1 << 23) && !uf) begin
        if (e <= 1) uf = 1;
        else begin
          m = m * 2;
          e = e - 1;
          n = n + 1;
        end
      end
      r = uf ? 32'd0 : {s, 8'(e), 23'(m)};
    end
    lat = 4 + d + n;
  endfunction

  int          cyc = 0;
  int          doneCyc = 0;
  int          mLat;
  bit          pending = 0;
  bit          expDone;
  logic [31:0] expRes = 32'd0;
  logic [31:0] lastRes = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending = 0;
      lastRes = 32'd0;
    end else begin
      if (pending) begin
        if (cyc == doneCyc) pending = 0;
      end else if (start) begin
        model(A, B, expRes, mLat);
        pending = 1;
        doneCyc = cyc + mLat;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    expDone = pending && (cyc == doneCyc);
    if (expDone) lastRes = expRes;
    check("cyc busy", {31'd0, busy}, {31'd0, pending});
    check("cyc done", {31'd0, done}, {31'd0, expDone});
    check("cyc result", result, lastRes);
  end

  task automatic runOp(input string name, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want,
                       input int wantLat);
    int c;
    @(posedge clk); #2;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    c = 1;
    while (!done && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, " done seen"}, {31'd0, done}, 32'd1);
    check({name, " result"}, result, want);
    check({name, " latency"}, c, wantLat);
  endtask

  int nd, c2;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = 32'd0;
    B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    runOp("3-1", 32'h40400000, 32'h3F800000, 32'h40000000, 5);
    runOp("1--1", 32'h3F800000, 32'hBF800000, 32'h40000000, 4);
    runOp("ovf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4);
    runOp("1-1.5", 32'h3F800000, 32'h3FC00000, 32'hBF000000, 5);
    runOp("x-x", 32'h3F800000, 32'h3F800000, 32'h00000000, 4);
    runOp("gap24", 32'h4B800000, 32'h3F800000, 32'h4B800000, 28);
    runOp("gap40", 32'h4B800000, 32'h37800000, 32'h4B800000, 4);
    runOp("5-3", 32'h40A00000, 32'h40400000, 32'h40000000, 6);
    runOp("-2-1", 32'hC0000000, 32'h3F800000, 32'hC0400000, 5);
    runOp("1-3", 32'h3F800000, 32'h40400000, 32'hC0000000, 5);
    runOp("uf0", 32'h00800001, 32'h00800000, 32'h00000000, 4);
    runOp("uf1", 32'h01000001, 32'h01000000, 32'h00000000, 5);

    // start held for 10 cycles on a 28-cycle op: exactly one pulse
    @(posedge clk); #2;
    A = 32'h4B800000;
    B = 32'h3F800000;
    start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (i == 10) start = 1'b0;
    end
    check("hold start pulses", nd, 1);
    check("hold start result", result, 32'h4B800000);

    // back-to-back: start stays high through DONE
    @(posedge clk); #2;
    A = 32'h40400000;
    B = 32'h3F800000;
    start = 1'b1;
    c2 = 0;
    while (!done && c2 < 100) begin
      @(posedge clk); #1;
      c2++;
    end
    check("b2b first result", result, 32'h40000000);
    A = 32'h3F800000;
    B = 32'h3FC00000;
    c2 = 0;
    do begin
      @(posedge clk); #1;
      c2++;
      if (c2 == 2) start = 1'b0;
    end while (!done && c2 < 100);
    check("b2b gap", c2, 6);
    check("b2b second result", result, 32'hBF000000);

    // asynchronous reset in the middle of a long alignment
    @(posedge clk); #2;
    A = 32'h4B800000;
    B = 32'h3F800000;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    runOp("post-rst", 32'h40400000, 32'h3F800000, 32'h40000000, 5);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
